mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage data-memory sequencer for the LC-3b pipeline; sits downstream of ex_mem.
//  Consumes the instruction held in ex_mem and runs 1-2 data-cache accesses over a
//  read/write-resp handshake: LDB/LDW/LDI/STB/STW/STI, plus the TRAP vector fetch.
//  Stalls the pipeline until the final access completes, then presents load data to mem_wb.
// PARAMETERS
//  WAIT_LIMIT  255  max cycles per access awaiting dmem_resp; 0 disables the watchdog
// PORTS
//  clk            in   1   clock, rising edge
//  reset_n        in   1   reset, asynchronous, active-low
//  exm_valid      in   1   ex_mem holds a real instruction (0 = bubble)
//  exm_opcode     in   4   lc3b opcode from ex_mem
//  exm_addr       in   16  effective address computed in EX
//  exm_sr_data    in   16  store source register value
//  dmem_resp      in   1   one-cycle completion pulse for the current access
//  dmem_rdata     in   16  read data, valid with dmem_resp
//  dmem_read      out  1   read strobe
//  dmem_write     out  1   write strobe
//  dmem_addr      out  16  access address
//  dmem_wdata     out  16  write data
//  dmem_byte_en   out  2   byte enables {hi,lo}
//  mem_stall      out  1   1 = freeze PC, if_id, id_ex and ex_mem; 0 = advance
//  mem_rdata      out  16  load/TRAP-vector result for mem_wb
//  mem_timeout    out  1   sticky watchdog flag
// BEHAVIOUR
//  Decided interface facts: one clock, clk; reset_n is asynchronous and active-low.
//  Reset (async, any state): state=IDLE; all outputs 0; mem_timeout cleared.
//  Mem op = exm_valid & opcode in {LDB,LDW,LDI,STB,STW,STI,TRAP}. All other instructions
//   and bubbles pass through with mem_stall=0; mem_rdata is held.
//  States: IDLE, RD1, RD2, WR, DONE.
//   IDLE: on a mem op, mem_stall=1 (combinational) and capture addr/data.
//    Next state: WR for STB/STW; RD1 for all other mem ops.
//   RD1: dmem_read=1 at the captured addr.
//    On resp: LDB/LDW/TRAP -> DONE; LDI -> RD2 (ptr=rdata); STI -> WR (ptr=rdata).
//   RD2: read at ptr; on resp -> DONE.
//   WR: dmem_write=1; on resp -> DONE.
//   DONE: mem_stall=0 for exactly 1 cycle, so the pipeline advances; then IDLE.
//  mem_stall=1 in RD1/RD2/WR. Strobes are held steady until the dmem_resp cycle inclusive.
//   They drop in the next cycle; resp outside RD1/RD2/WR is ignored.
//  Latency: 1 + sum over accesses of (cycles until resp) + 1 (DONE).
//   With a 1-cycle resp, LDW = 3 cycles and LDI/STI = 4 cycles.
//  Word ops drive dmem_addr[0]=0 and byte_en=2'b11.
//   LDI/STI pointers are word-aligned in the same way.
//  LDB: lane = addr[0] (1 = high byte); mem_rdata = sign-extended byte; byte_en = 2'b11.
//  STB: wdata = {sr[7:0], sr[7:0]}; byte_en = addr[0] ? 2'b10 : 2'b01.
//  mem_rdata updates only on the final read resp. Stores leave it unchanged.
//  Watchdog: a per-access counter is cleared on entry to each access state.
//   If it reaches WAIT_LIMIT without resp: set mem_timeout, drop the strobe, go to DONE.
//   mem_rdata is unchanged in that case.
//  exm_* is sampled only in IDLE; changes during RD1/RD2/WR are ignored.
// STRUCTURE
//  lc3b_types gains: lc3b_word typedef, mem_state_t enum, opcode constants, is_mem_op().
//  One sub-module: mem_byte_lane (combinational).
//   Covers load byte extract/sign-extend and store replicate/byte-enable generation.
// TESTING
//  LDW addr=0x3001, resp after 2 cycles with 0xBEEF:
//   -> dmem_addr=0x3000; stall for 3 cycles; DONE; mem_rdata=0xBEEF.
//  LDB addr=0x1235, rdata=0x80FF -> byte_en=11; mem_rdata=0xFF80.
//   Repeat with addr=0x1234 -> mem_rdata=0xFFFF.
//  STB addr=0x0011, sr=0x1234 -> one write; wdata=0x3434; byte_en=10; mem_rdata unchanged.
//  STI addr=0x4000, mem[0x4000]=0x5003, sr=0xCAFE -> read 0x4000, then write 0x5002.
//   Write has wdata=0xCAFE, byte_en=11; 4 cycles total with immediate resp.
//  LDI, then pulse reset_n low during RD2:
//   -> strobes drop at once; IDLE; mem_rdata=0.
//   Next LDW after reset completes normally.
//  WAIT_LIMIT=4, no resp -> strobe held 4 cycles; mem_timeout=1 and stays 1; DONE; IDLE.
//   Bubble/ADD back-to-back with LDW -> no stall on the ADD.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types for the MEM stage: word type, sequencer states, opcodes,
// and the mem-op decode used by the data-memory sequencer.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_opcode;

    typedef enum logic [2:0] {
        MS_IDLE,
        MS_RD1,
        MS_RD2,
        MS_WR,
        MS_DONE
    } mem_state_t;

    localparam lc3b_opcode OP_ADD  = 4'h1;
    localparam lc3b_opcode OP_LDB  = 4'h2;
    localparam lc3b_opcode OP_STB  = 4'h3;
    localparam lc3b_opcode OP_LDW  = 4'h6;
    localparam lc3b_opcode OP_STW  = 4'h7;
    localparam lc3b_opcode OP_LDI  = 4'hA;
    localparam lc3b_opcode OP_STI  = 4'hB;
    localparam lc3b_opcode OP_TRAP = 4'hF;

    function automatic logic is_mem_op(input logic valid, input lc3b_opcode op);
        logic hit;
        case (op)
            OP_LDB, OP_LDW, OP_LDI, OP_STB, OP_STW, OP_STI, OP_TRAP: hit = 1'b1;
            default:                                                 hit = 1'b0;
        endcase
        return valid & hit;
    endfunction

    function automatic lc3b_word word_align(input lc3b_word a);
        return {a[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for the MEM stage: load byte select with sign extension,
// and store byte replication with byte-enable generation.
module mem_byte_lane
    import lc3b_types::*;
(
    input  logic       ld_byte_i,
    input  logic       ld_lane_i,
    input  lc3b_word   rdata_i,
    output lc3b_word   ld_data_o,
    input  logic       st_byte_i,
    input  logic       st_lane_i,
    input  lc3b_word   sr_i,
    output lc3b_word   st_wdata_o,
    output logic [1:0] st_byte_en_o
);

    logic [7:0] ld_sel;

    always_comb begin
        ld_sel       = ld_lane_i ? rdata_i[15:8] : rdata_i[7:0];
        ld_data_o    = ld_byte_i ? {{8{ld_sel[7]}}, ld_sel} : rdata_i;
        st_wdata_o   = st_byte_i ? {sr_i[7:0], sr_i[7:0]} : sr_i;
        st_byte_en_o = st_byte_i ? (st_lane_i ? 2'b10 : 2'b01) : 2'b11;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: runs 1-2 dcache accesses per load/store/TRAP,
// stalling the pipeline until the final response, with a per-access watchdog.
module mem_access_ctrl
    import lc3b_types::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       exm_valid,
    input  lc3b_opcode exm_opcode,
    input  lc3b_word   exm_addr,
    input  lc3b_word   exm_sr_data,
    input  logic       dmem_resp,
    input  lc3b_word   dmem_rdata,
    output logic       dmem_read,
    output logic       dmem_write,
    output lc3b_word   dmem_addr,
    output lc3b_word   dmem_wdata,
    output logic [1:0] dmem_byte_en,
    output logic       mem_stall,
    output lc3b_word   mem_rdata,
    output logic       mem_timeout
);

    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    mem_state_t  state_q;
    lc3b_opcode  op_q;
    logic        lane_q;
    lc3b_word    sr_q;
    logic [CW-1:0] wait_cnt_q;
    logic        rd_q;
    logic        wr_q;
    lc3b_word    daddr_q;
    lc3b_word    wdata_q;
    logic [1:0]  be_q;
    lc3b_word    rdata_q;
    logic        timeout_q;

    logic        mem_op;
    logic        wd_expire;
    lc3b_word    lane_ld_data;
    lc3b_word    lane_st_wdata;
    logic [1:0]  lane_st_be;

    assign mem_op    = is_mem_op(exm_valid, exm_opcode);
    assign wd_expire = (WAIT_LIMIT != 0) && (wait_cnt_q == CW'(WAIT_LIMIT - 1));

    // Load steering uses the captured instruction; store steering uses live ex_mem
    // because write data is registered on the IDLE -> WR transition.
    mem_byte_lane u_lane (
        .ld_byte_i   (op_q == OP_LDB),
        .ld_lane_i   (lane_q),
        .rdata_i     (dmem_rdata),
        .ld_data_o   (lane_ld_data),
        .st_byte_i   (exm_opcode == OP_STB),
        .st_lane_i   (exm_addr[0]),
        .sr_i        (exm_sr_data),
        .st_wdata_o  (lane_st_wdata),
        .st_byte_en_o(lane_st_be)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= MS_IDLE;
            op_q       <= '0;
            lane_q     <= 1'b0;
            sr_q       <= '0;
            wait_cnt_q <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            daddr_q    <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                MS_IDLE: begin
                    if (mem_op) begin
                        op_q       <= exm_opcode;
                        lane_q     <= exm_addr[0];
                        sr_q       <= exm_sr_data;
                        wait_cnt_q <= '0;
                        if (exm_opcode == OP_STB || exm_opcode == OP_STW) begin
                            state_q <= MS_WR;
                            wr_q    <= 1'b1;
                            daddr_q <= (exm_opcode == OP_STB) ? exm_addr : word_align(exm_addr);
                            wdata_q <= lane_st_wdata;
                            be_q    <= lane_st_be;
                        end else begin
                            state_q <= MS_RD1;
                            rd_q    <= 1'b1;
                            daddr_q <= (exm_opcode == OP_LDB) ? exm_addr : word_align(exm_addr);
                            be_q    <= 2'b11;
                        end
                    end
                end
                MS_RD1: begin
                    if (dmem_resp) begin
                        wait_cnt_q <= '0;
                        case (op_q)
                            OP_LDI: begin
                                state_q <= MS_RD2;
                                daddr_q <= word_align(dmem_rdata);
                            end
                            OP_STI: begin
                                state_q <= MS_WR;
                                rd_q    <= 1'b0;
                                wr_q    <= 1'b1;
                                daddr_q <= word_align(dmem_rdata);
                                wdata_q <= sr_q;
                                be_q    <= 2'b11;
                            end
                            default: begin
                                state_q <= MS_DONE;
                                rd_q    <= 1'b0;
                                rdata_q <= lane_ld_data;
                            end
                        endcase
                    end else if (wd_expire) begin
                        state_q   <= MS_DONE;
                        rd_q      <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                MS_RD2: begin
                    if (dmem_resp) begin
                        state_q <= MS_DONE;
                        rd_q    <= 1'b0;
                        rdata_q <= dmem_rdata;
                    end else if (wd_expire) begin
                        state_q   <= MS_DONE;
                        rd_q      <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                MS_WR: begin
                    if (dmem_resp) begin
                        state_q <= MS_DONE;
                        wr_q    <= 1'b0;
                    end else if (wd_expire) begin
                        state_q   <= MS_DONE;
                        wr_q      <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                MS_DONE: state_q <= MS_IDLE;
                default: state_q <= MS_IDLE;
            endcase
        end
    end

    // Stall is raised combinationally in IDLE so the mem op never slips past ex_mem.
    assign mem_stall = ((state_q == MS_IDLE) && mem_op) || (state_q == MS_RD1)
                     || (state_q == MS_RD2) || (state_q == MS_WR);

    assign dmem_read    = rd_q;
    assign dmem_write   = wr_q;
    assign dmem_addr    = daddr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_byte_en = be_q;
    assign mem_rdata    = rdata_q;
    assign mem_timeout  = timeout_q;

endmodule
